ir_receiver: RTL and testbench
==============================

Name: ir_receiver

Overview:
- Decodes the serial IR line protocol back into 32-bit words.
- Sits directly downstream of the IR transmitter, on the receive side of the link; rx_port is driven by the IR detector output (or, in simulation, looped back from tx_port).
- Measures the high-pulse ("mark") widths and the low gaps with a cycle counter.
- Rebuilds the word MSB first and presents it with a one-cycle valid strobe, or flags a framing error.

Parameters:
- BASE_DELAY, 250: cycles per protocol time unit (TU). Must be >= 4. Must match the transmitter setting.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- rx_port  in  1  asynchronous IR line (idle low)
- rx_data  out  32  last correctly received word
- rx_valid  out  1  one-cycle strobe; rx_data updated on the same cycle
- rx_error  out  1  one-cycle strobe on a framing error
- rx_busy  out  1  high while a frame is in progress

Behaviour:
- Reset: reset reset_n, synchronous, active-low; clock clock.
  - rx_data=0, rx_valid=0, rx_error=0, rx_busy=0.
  - Synchronizer flops reset to 0; state=IDLE; counters=0.
- Line frame format, line idle low:
  - Start mark: high 4 TU.
  - Then 32 bits, MSB first. Each bit is a low gap of 1 TU, then a mark: 1 TU = '0', 2 TU = '1'.
  - Then a low gap of 1 TU, a stop mark of 3 TU, then low.
- Input path:
  - rx_port passes through a 2-FF synchronizer, giving s.
  - An edge detector compares s against its 1-cycle-delayed copy.
- Mark width w = number of cycles s is high. The counter restarts at 1 on a rising edge and saturates at 5*BD.
- Mark classes (integer division, BD = BASE_DELAY):
  - w < BD/2: GLITCH
  - < 3BD/2: ZERO
  - < 5BD/2: ONE
  - < 7BD/2: STOP
  - < 9BD/2: START
  - otherwise: LONG
- A mark is classified on its falling edge. LONG is also declared as soon as the counter reaches 9BD/2 while the line is still high.
- Gap timeout: inside a frame, s low for more than 2*BD consecutive cycles.
- States:
  - IDLE:
    - On a rising edge go to START_MARK.
    - rx_busy=0.
  - START_MARK:
    - On the falling edge, class START → GAP: bit_cnt=0, shift register cleared, rx_busy=1.
    - Any other class → IDLE, silently (no error). This rejects noise before a frame.
    - LONG → WAIT_LOW, silently.
  - GAP:
    - Count low cycles. A rising edge → MARK.
    - Timeout → error.
  - MARK (falling edge):
    - If bit_cnt < 32:
      - ZERO or ONE: shift the bit in at the LSB, bit_cnt+1, → GAP.
      - Any other class: error.
    - If bit_cnt == 32:
      - STOP: rx_data <= shift register, rx_valid=1 for one cycle, → IDLE.
      - Any other class: error.
    - LONG while high: error, → WAIT_LOW.
  - Error handling:
    - rx_error=1 for one cycle, rx_busy=0.
    - rx_data is unchanged; the partial word is discarded.
    - Next state is IDLE if the line is low, else WAIT_LOW.
  - WAIT_LOW:
    - Stay until s is low, then → IDLE.
    - No further error pulses.
- Latency:
  - rx_valid asserts exactly 3 clock edges after the first edge that samples rx_port low at the end of the stop mark (2 for the synchronizer, 1 for edge detect/register).
  - rx_error from a bad class has the same latency.
- rx_valid and rx_error are never high on the same cycle.
- rx_busy falls on the same cycle as rx_valid or rx_error.
- A new frame may start immediately after IDLE is entered; no minimum idle time is required.
- Reset mid-frame: immediate return to the reset state; no strobes are produced.
- Bit counter is 6 bits wide. The mark counter is wide enough for 5*BD without wrap.

Test Plan (BASE_DELAY=10; thresholds 5/15/25/35/45):
- Clean frame 0xA5A51234: start 40, gaps 10, marks 10/20, stop 30 → one rx_valid; rx_data=0xA5A51234; rx_busy high from the start-mark fall to valid; rx_error never.
- Two frames back-to-back, 0xFFFFFFFF then 0x00000000, with no idle gap → two rx_valid strobes with the correct words.
- Frame whose bit 5 mark is 30 cycles → rx_error pulse at that mark's fall; rx_data keeps its previous value; the next clean frame 0x12345678 is received correctly.
- Gap of 25 cycles after bit 10 → rx_error 21 cycles into the gap (timeout); rx_busy=0.
- Noise: isolated 3-cycle and 12-cycle highs while idle → no strobes, stays idle. 60-cycle high mid-frame → rx_error when the count reaches 45; no further strobes until the line falls.
- Assert reset_n=0 during bit 20, then send a clean frame 0xDEADBEEF → no strobe from the aborted frame; all outputs 0 after reset; rx_data=0xDEADBEEF after the new frame.

Source files
------------

// File: rtl/ir_receiver.sv
// IR line receiver: times marks/gaps on the synchronized line and rebuilds MSB-first 32-bit words.
// rx_valid/rx_error are registered strobes issued on the third edge after rx_port changes; no backpressure.
module ir_receiver #(
    parameter int BASE_DELAY = 250
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_port,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        rx_error,
    output logic        rx_busy
);
    localparam int SAT = 5 * BASE_DELAY;
    localparam int CW  = $clog2(SAT + 1);
    localparam int GW  = $clog2(2 * BASE_DELAY + 1);

    localparam logic [CW-1:0] CNT_SAT  = CW'(SAT);
    localparam logic [CW-1:0] TH_ZERO  = CW'(BASE_DELAY / 2);
    localparam logic [CW-1:0] TH_ONE   = CW'(3 * BASE_DELAY / 2);
    localparam logic [CW-1:0] TH_STOP  = CW'(5 * BASE_DELAY / 2);
    localparam logic [CW-1:0] TH_START = CW'(7 * BASE_DELAY / 2);
    localparam logic [CW-1:0] TH_LONG  = CW'(9 * BASE_DELAY / 2);
    localparam logic [GW-1:0] GAP_MAX  = GW'(2 * BASE_DELAY);

    typedef enum logic [2:0] {IDLE, START_MARK, GAP, MARK, WAIT_LOW} state_t;
    typedef enum logic [2:0] {C_GLITCH, C_ZERO, C_ONE, C_STOP, C_START, C_LONG} mark_class_t;

    logic          sync1_q, sync2_q, s_dly_q;
    logic          rise, fall, long_now;
    logic [CW-1:0] mark_cnt_q, mark_cnt_d;
    mark_class_t   cls;

    state_t        state_q;
    logic [5:0]    bit_cnt_q;
    logic [31:0]   shift_q;
    logic [GW-1:0] gap_cnt_q;
    logic [31:0]   rx_data_q;
    logic          rx_valid_q, rx_error_q, rx_busy_q;

    assign rise     = sync2_q & ~s_dly_q;
    assign fall     = ~sync2_q & s_dly_q;
    assign long_now = sync2_q && (mark_cnt_q >= TH_LONG);

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_error = rx_error_q;
    assign rx_busy  = rx_busy_q;

    // On the falling-edge cycle mark_cnt_q holds exactly the number of high cycles.
    always_comb begin
        mark_cnt_d = mark_cnt_q;
        if (rise) begin
            mark_cnt_d = CW'(1);
        end else if (sync2_q && (mark_cnt_q < CNT_SAT)) begin
            mark_cnt_d = mark_cnt_q + 1'b1;
        end
    end

    always_comb begin
        if (mark_cnt_q < TH_ZERO) begin
            cls = C_GLITCH;
        end else if (mark_cnt_q < TH_ONE) begin
            cls = C_ZERO;
        end else if (mark_cnt_q < TH_STOP) begin
            cls = C_ONE;
        end else if (mark_cnt_q < TH_START) begin
            cls = C_STOP;
        end else if (mark_cnt_q < TH_LONG) begin
            cls = C_START;
        end else begin
            cls = C_LONG;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            s_dly_q    <= 1'b0;
            mark_cnt_q <= '0;
        end else begin
            sync1_q    <= rx_port;
            sync2_q    <= sync1_q;
            s_dly_q    <= sync2_q;
            mark_cnt_q <= mark_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            gap_cnt_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
            rx_busy_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    rx_busy_q <= 1'b0;
                    if (rise) begin
                        state_q <= START_MARK;
                    end
                end
                // Anything but a proper start mark is treated as pre-frame noise.
                START_MARK: begin
                    if (long_now) begin
                        state_q <= WAIT_LOW;
                    end else if (fall) begin
                        if (cls == C_START) begin
                            bit_cnt_q <= '0;
                            shift_q   <= '0;
                            gap_cnt_q <= GW'(1);
                            rx_busy_q <= 1'b1;
                            state_q   <= GAP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (sync2_q) begin
                        state_q <= MARK;
                    end else if (gap_cnt_q >= GAP_MAX) begin
                        rx_error_q <= 1'b1;
                        rx_busy_q  <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                MARK: begin
                    if (long_now) begin
                        rx_error_q <= 1'b1;
                        rx_busy_q  <= 1'b0;
                        state_q    <= WAIT_LOW;
                    end else if (fall) begin
                        if ((bit_cnt_q < 6'd32) && ((cls == C_ZERO) || (cls == C_ONE))) begin
                            shift_q   <= {shift_q[30:0], (cls == C_ONE)};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            gap_cnt_q <= GW'(1);
                            state_q   <= GAP;
                        end else if ((bit_cnt_q == 6'd32) && (cls == C_STOP)) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            rx_busy_q  <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            rx_error_q <= 1'b1;
                            rx_busy_q  <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
                WAIT_LOW: begin
                    if (!sync2_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ir_receiver.sv
// Bench for ir_receiver: builds a line waveform, predicts per-cycle outputs from run lengths, compares every cycle.
module tb_ir_receiver;
    localparam int BD      = 10;
    localparam int T_ZERO  = BD / 2;
    localparam int T_ONE   = 3 * BD / 2;
    localparam int T_STOP  = 5 * BD / 2;
    localparam int T_START = 7 * BD / 2;
    localparam int T_LONG  = 9 * BD / 2;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_port = 1'b0;
    logic [31:0] rx_data;
    logic        rx_valid, rx_error, rx_busy;

    ir_receiver #(.BASE_DELAY(BD)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .rx_port (rx_port),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_error(rx_error),
        .rx_busy (rx_busy)
    );

    always #5 clock = ~clock;

    bit          line_q[$];
    bit          rst_q[$];
    bit          exp_v[$], exp_e[$], exp_b[$];
    logic [31:0] exp_d[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, want);
        end
    endtask

    task automatic emit(input bit lvl, input int n);
        for (int i = 0; i < n; i++) begin
            line_q.push_back(lvl);
            rst_q.push_back(1'b1);
        end
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            line_q.push_back(1'b0);
            rst_q.push_back(1'b0);
        end
    endtask

    function automatic int pick(input bit rnd, input int lo, input int hi, input int nom);
        return rnd ? int'($urandom_range(hi, lo)) : nom;
    endfunction

    // mut_*: override one mark / one gap (index 32 = gap before stop); cut_bit truncates inside that mark.
    task automatic send_frame(input logic [31:0] word, input bit rnd, input int mut_bit, input int mut_mark,
                              input int mut_gap_bit, input int mut_gap, input int cut_bit);
        emit(1'b1, pick(rnd, T_START, T_LONG - 1, 4 * BD));
        for (int i = 0; i < 32; i++) begin
            int g;
            int m;
            g = (i == mut_gap_bit) ? mut_gap : pick(rnd, 1, 2 * BD, BD);
            emit(1'b0, g);
            m = word[31 - i] ? pick(rnd, T_ONE, T_STOP - 1, 2 * BD) : pick(rnd, T_ZERO, T_ONE - 1, BD);
            if (i == mut_bit) m = mut_mark;
            if (i == cut_bit) begin
                emit(1'b1, m / 2);
                return;
            end
            emit(1'b1, m);
        end
        emit(1'b0, (mut_gap_bit == 32) ? mut_gap : pick(rnd, 1, 2 * BD, BD));
        emit(1'b1, pick(rnd, T_STOP, T_START - 1, 3 * BD));
    endtask

    // 0 glitch, 1 zero, 2 one, 3 stop, 4 start, 5 long
    function automatic int klass(input int w);
        if (w < T_ZERO) return 0;
        if (w < T_ONE) return 1;
        if (w < T_STOP) return 2;
        if (w < T_START) return 3;
        if (w < T_LONG) return 4;
        return 5;
    endfunction

    // Reference: walk high/low runs of each reset-free stretch; an event decided by line sample e
    // shows on the outputs after edge e+2. Kinds: 0 frame start, 1 word, 2 error.
    task automatic build_expect();
        int          n, k, ps, pe, j, len, c, nb, qi;
        bit          lvl, ends, in_frame, busy, v, er;
        logic [31:0] word, data;
        int          ev_at[$], ev_kind[$];
        logic [31:0] ev_word[$];
        n = line_q.size();
        k = 0;
        data = '0;
        while (k < n) begin
            if (!rst_q[k]) begin
                data = '0;
                exp_v.push_back(1'b0); exp_e.push_back(1'b0); exp_b.push_back(1'b0); exp_d.push_back(data);
                k++;
            end else begin
                ps = k;
                pe = k;
                while (pe < n && rst_q[pe]) pe++;
                ev_at.delete(); ev_kind.delete(); ev_word.delete();
                in_frame = 1'b0; nb = 0; word = '0;
                j = ps;
                while (j < pe) begin
                    lvl = line_q[j];
                    len = 0;
                    while (j + len < pe && line_q[j + len] == lvl) len++;
                    ends = (j + len < pe);
                    if (lvl) begin
                        if (in_frame) begin
                            if (len >= T_LONG) begin
                                ev_at.push_back(j + T_LONG); ev_kind.push_back(2); ev_word.push_back(0);
                                in_frame = 1'b0;
                            end else if (ends) begin
                                c = klass(len);
                                if (nb < 32 && (c == 1 || c == 2)) begin
                                    word = word * 2 + ((c == 2) ? 32'd1 : 32'd0);
                                    nb++;
                                end else if (nb == 32 && c == 3) begin
                                    ev_at.push_back(j + len); ev_kind.push_back(1); ev_word.push_back(word);
                                    in_frame = 1'b0;
                                end else begin
                                    ev_at.push_back(j + len); ev_kind.push_back(2); ev_word.push_back(0);
                                    in_frame = 1'b0;
                                end
                            end
                        end else if (ends && klass(len) == 4) begin
                            ev_at.push_back(j + len); ev_kind.push_back(0); ev_word.push_back(0);
                            in_frame = 1'b1; nb = 0; word = '0;
                        end
                    end else if (in_frame && len > 2 * BD) begin
                        ev_at.push_back(j + 2 * BD); ev_kind.push_back(2); ev_word.push_back(0);
                        in_frame = 1'b0;
                    end
                    j += len;
                end
                busy = 1'b0;
                qi = 0;
                for (int t = ps; t < pe; t++) begin
                    v = 1'b0;
                    er = 1'b0;
                    while (qi < ev_at.size() && ev_at[qi] + 2 == t) begin
                        if (ev_kind[qi] == 0) busy = 1'b1;
                        else if (ev_kind[qi] == 1) begin v = 1'b1; busy = 1'b0; data = ev_word[qi]; end
                        else begin er = 1'b1; busy = 1'b0; end
                        qi++;
                    end
                    exp_v.push_back(v); exp_e.push_back(er); exp_b.push_back(busy); exp_d.push_back(data);
                end
                k = pe;
            end
        end
    endtask

    initial begin
        hold_reset(4);
        emit(1'b0, 6);
        send_frame(32'hA5A51234, 1'b0, -1, 0, -1, 0, -1);
        emit(1'b0, 10);
        send_frame(32'hFFFFFFFF, 1'b0, -1, 0, -1, 0, -1);
        emit(1'b0, 1);
        send_frame(32'h00000000, 1'b0, -1, 0, -1, 0, -1);
        emit(1'b0, 10);
        send_frame($urandom, 1'b0, 5, 3 * BD, -1, 0, -1);          // bit 5 mark is a stop-width mark
        emit(1'b0, 10);
        send_frame(32'h12345678, 1'b0, -1, 0, -1, 0, -1);
        emit(1'b0, 10);
        send_frame($urandom, 1'b0, -1, 0, 11, 25, -1);             // over-long gap after bit 10
        emit(1'b0, 10);
        emit(1'b1, 3); emit(1'b0, 15); emit(1'b1, 12); emit(1'b0, 15);
        send_frame($urandom, 1'b0, 7, 60, -1, 0, -1);              // 60-cycle mark mid-frame
        emit(1'b0, 10);
        send_frame($urandom, 1'b0, -1, 0, -1, 0, 20);              // aborted by reset inside bit 20
        hold_reset(4);
        emit(1'b0, 5);
        send_frame(32'hDEADBEEF, 1'b0, -1, 0, -1, 0, -1);
        emit(1'b0, 10);
        for (int f = 0; f < 6; f++) begin
            int mb, mm, gb, gl;
            mb = -1; mm = 0; gb = -1; gl = 0;
            if ($urandom_range(2, 0) == 0) begin
                mb = int'($urandom_range(31, 0));
                mm = int'($urandom_range(60, 1));
            end
            if ($urandom_range(3, 0) == 0) begin
                gb = int'($urandom_range(32, 0));
                gl = int'($urandom_range(30, 1));
            end
            send_frame($urandom, 1'b1, mb, mm, gb, gl, -1);
            emit(1'b0, int'($urandom_range(30, 1)));
        end
        emit(1'b0, 60);

        build_expect();

        for (int k = 0; k < line_q.size(); k++) begin
            rx_port = line_q[k];
            reset_n = rst_q[k];
            @(posedge clock);
            #1;
            cyc = k;
            check_eq("rx_valid", 32'(rx_valid), 32'(exp_v[k]));
            check_eq("rx_error", 32'(rx_error), 32'(exp_e[k]));
            check_eq("rx_busy", 32'(rx_busy), 32'(exp_b[k]));
            check_eq("rx_data", rx_data, exp_d[k]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
